// File: rtl/io_switch_led_ctrl.sv
// io_switch_led_ctrl: board IO peripheral on the CPU IO bus.
//   - 24 slide switches: two-flop synchroniser, whole-vector debounce, gated
//     combinational read onto io_rdata.
//   - 24 LEDs: register loaded by the LEDCtrl store strobe.
//   - 6-digit hex seven-segment scan of the LED register, built only when the
//     macro IO_SEG7_EN is defined; otherwise seg_an/seg_cat are tied off (FF).
// Reset is synchronous and active-low.
module io_switch_led_ctrl #(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int SCAN_CYCLES     = 100000,
  parameter int IO_W            = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IO_W-1:0] io_wdata,
  input  logic            LEDCtrl,
  input  logic            SwitchCtrl,
  output logic [IO_W-1:0] io_rdata,
  input  logic [IO_W-1:0] sw_in,
  output logic [IO_W-1:0] led_out,
  output logic [7:0]      seg_an,
  output logic [7:0]      seg_cat
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [IO_W-1:0] sw_s1_q, sw_s2_q, sw_prev_q;
  logic [IO_W-1:0] sw_stable_q, sw_stable_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [IO_W-1:0] led_q;

  // Two-flop synchroniser for the raw pins, plus one more stage for edge compare.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      sw_prev_q <= '0;
    end else begin
      sw_s1_q   <= sw_in;
      sw_s2_q   <= sw_s1_q;
      sw_prev_q <= sw_s2_q;
    end
  end

  // Debounce next state: any bit change restarts the window; counter saturates.
  always_comb begin
    db_cnt_d    = db_cnt_q;
    sw_stable_d = sw_stable_q;
    if (sw_s2_q != sw_prev_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      sw_stable_d = sw_s2_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      db_cnt_q    <= '0;
      sw_stable_q <= '0;
    end else begin
      db_cnt_q    <= db_cnt_d;
      sw_stable_q <= sw_stable_d;
    end
  end

  // LED register: loaded on every cycle the store strobe is high (last wins).
  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q <= '0;
    end else if (LEDCtrl) begin
      led_q <= io_wdata;
    end
  end

  // Combinational read so a single-cycle lw sees the debounced switches.
  assign io_rdata = SwitchCtrl ? sw_stable_q : '0;
  assign led_out  = led_q;

`ifdef IO_SEG7_EN
  localparam int SC_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_CYCLES - 1);

  localparam logic [2:0] SCAN0 = 3'd0;
  localparam logic [2:0] SCAN1 = 3'd1;
  localparam logic [2:0] SCAN2 = 3'd2;
  localparam logic [2:0] SCAN3 = 3'd3;
  localparam logic [2:0] SCAN4 = 3'd4;
  localparam logic [2:0] SCAN5 = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [SC_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [7:0]      seg_an_q, seg_an_d;
  logic [7:0]      seg_cat_q, seg_cat_d;
  logic [23:0]     led_pad;

  assign led_pad = 24'(led_q);

  // Hex font, active low, decimal point off.
  function automatic logic [7:0] hex7seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex7seg = 8'hC0;
      4'h1: hex7seg = 8'hF9;
      4'h2: hex7seg = 8'hA4;
      4'h3: hex7seg = 8'hB0;
      4'h4: hex7seg = 8'h99;
      4'h5: hex7seg = 8'h92;
      4'h6: hex7seg = 8'h82;
      4'h7: hex7seg = 8'hF8;
      4'h8: hex7seg = 8'h80;
      4'h9: hex7seg = 8'h90;
      4'hA: hex7seg = 8'h88;
      4'hB: hex7seg = 8'h83;
      4'hC: hex7seg = 8'hC6;
      4'hD: hex7seg = 8'hA1;
      4'hE: hex7seg = 8'h86;
      default: hex7seg = 8'h8E;
    endcase
  endfunction

  // Scan next state: at terminal count advance the digit and latch its
  // anode/cathode pattern, so a mid-digit LED write shows from the next digit.
  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q + SC_W'(1);
    seg_an_d   = seg_an_q;
    seg_cat_d  = seg_cat_q;
    if (scan_cnt_q == SC_LAST) begin
      scan_cnt_d = '0;
      state_d    = (state_q == SCAN5) ? SCAN0 : state_q + 3'd1;
      seg_an_d   = ~(8'h01 << state_d);
      seg_cat_d  = hex7seg(led_pad[{state_d, 2'b00} +: 4]);
    end
  end

  // Scan FSM and registered display outputs; blank until the first digit change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= SCAN0;
      scan_cnt_q <= '0;
      seg_an_q   <= 8'hFF;
      seg_cat_q  <= 8'hFF;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      seg_an_q   <= seg_an_d;
      seg_cat_q  <= seg_cat_d;
    end
  end

  assign seg_an  = seg_an_q;
  assign seg_cat = seg_cat_q;
`else
  assign seg_an  = 8'hFF;
  assign seg_cat = 8'hFF;
`endif

endmodule

// File: tb/tb_io_switch_led_ctrl.sv
// Testbench for io_switch_led_ctrl with short debounce/scan periods.
// Expectations under IO_SEG7_EN follow the build; without it the display
// outputs are expected to stay at FF.
module tb_io_switch_led_ctrl;

  localparam int D = 4;
  localparam int S = 3;
  localparam int W = 24;
`ifdef IO_SEG7_EN
  localparam bit SEG_EN = 1'b1;
`else
  localparam bit SEG_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] io_wdata, sw_in, io_rdata, led_out;
  logic         LEDCtrl, SwitchCtrl;
  logic [7:0]   seg_an, seg_cat;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [W-1:0] ph[$];
  int           n;
  logic [W-1:0] m_led, m_stable;
  logic [7:0]   m_an, m_cat;

  typedef struct {
    bit         do_tick;
    logic       ledc;
    logic       swc;
    logic [W-1:0] wdata;
    logic [W-1:0] exp_led;
    logic [W-1:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [7:0] an;
    logic [7:0] cat;
  } scan_t;

  vec_t  vt[8];
  scan_t st[7];

  io_switch_led_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .SCAN_CYCLES(S),
    .IO_W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_wdata(io_wdata),
    .LEDCtrl(LEDCtrl),
    .SwitchCtrl(SwitchCtrl),
    .io_rdata(io_rdata),
    .sw_in(sw_in),
    .led_out(led_out),
    .seg_an(seg_an),
    .seg_cat(seg_cat)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] font(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // Pin value sampled at the k-th edge after reset release; zero before that.
  function automatic logic [W-1:0] ph_at(input int k);
    if (k <= 0) return '0;
    return ph[k-1];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare.
  task automatic tick();
    bit same;
    int dg;
    @(posedge clk);
    if (!rst) begin
      ph.delete();
      n        = 0;
      m_led    = '0;
      m_stable = '0;
      m_an     = 8'hFF;
      m_cat    = 8'hFF;
    end else begin
      n++;
      ph.push_back(sw_in);
      // Stable once the synchronised value (2 edges late) held for D+1 samples.
      if (n >= D) begin
        same = 1'b1;
        for (int k = n - 2 - D; k < n - 2; k++)
          if (ph_at(k) !== ph_at(n - 2)) same = 1'b0;
        if (same) m_stable = ph_at(n - 2);
      end
      if (SEG_EN && (n % S == 0)) begin
        dg    = (n / S) % 6;
        m_an  = 8'hFF ^ (8'h01 << dg);
        m_cat = font(m_led[4*dg +: 4]);
      end
      if (LEDCtrl) m_led = io_wdata;
    end
    #1;
    check("model_led", led_out, m_led);
    check("model_rdata", io_rdata, SwitchCtrl ? m_stable : '0);
    check("model_an", {16'h0, seg_an}, {16'h0, m_an});
    check("model_cat", {16'h0, seg_cat}, {16'h0, m_cat});
  endtask

  initial begin
    logic [7:0] prev_an;
    bit         found;
    int         waited;

    vt[0] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000, 24'h000000};
    vt[1] = '{1'b0, 1'b0, 1'b1, 24'h000000, 24'h000000, 24'hA5A5A5};
    vt[2] = '{1'b1, 1'b1, 1'b0, 24'h123456, 24'h123456, 24'h000000};
    vt[3] = '{1'b1, 1'b0, 1'b0, 24'hFFFFFF, 24'h123456, 24'h000000};
    vt[4] = '{1'b1, 1'b1, 1'b1, 24'h654321, 24'h654321, 24'hA5A5A5};
    vt[5] = '{1'b1, 1'b1, 1'b0, 24'h111111, 24'h111111, 24'h000000};
    vt[6] = '{1'b1, 1'b1, 1'b0, 24'h0ABC9F, 24'h0ABC9F, 24'h000000};
    vt[7] = '{1'b1, 1'b0, 1'b1, 24'h000000, 24'h0ABC9F, 24'hA5A5A5};

    st[0] = '{8'hFE, 8'h8E};
    st[1] = '{8'hFD, 8'h90};
    st[2] = '{8'hFB, 8'hC6};
    st[3] = '{8'hF7, 8'h83};
    st[4] = '{8'hEF, 8'h88};
    st[5] = '{8'hDF, 8'hC0};
    st[6] = '{8'hFE, 8'h8E};

    n = 0; m_led = '0; m_stable = '0; m_an = 8'hFF; m_cat = 8'hFF;

    // Reset with switches high and a write strobe pending.
    rst = 1'b0; sw_in = 24'hFFFFFF; LEDCtrl = 1'b1; io_wdata = 24'h777777; SwitchCtrl = 1'b1;
    tick();
    tick();
    check("rst_led", led_out, 24'h0);
    check("rst_rdata", io_rdata, 24'h0);
    check("rst_an", {16'h0, seg_an}, 24'h0000FF);
    check("rst_cat", {16'h0, seg_cat}, 24'h0000FF);

    // Release: switches appear after 7..8 cycles.
    rst = 1'b1; LEDCtrl = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k <= 6) check("rel_rdata_early", io_rdata, 24'h0);
      if (k == 8) check("rel_rdata_late", io_rdata, 24'hFFFFFF);
    end

    // Back to all-zero switches.
    sw_in = 24'h0;
    repeat (8) tick();
    check("stable_zero", io_rdata, 24'h0);

    // Bounce on bit 0, toggled every 2 cycles, then steady 1.
    for (int i = 0; i < 10; i++) begin
      sw_in = ((i / 2) % 2 == 0) ? 24'h000001 : 24'h000000;
      tick();
      check("bounce_rdata", io_rdata, 24'h0);
    end
    for (int t = 3; t <= 8; t++) begin
      tick();
      check("settle_rdata", io_rdata, (t >= 7) ? 24'h000001 : 24'h000000);
    end

    // Read gating and LED write vectors.
    sw_in = 24'hA5A5A5; SwitchCtrl = 1'b0;
    repeat (9) tick();
    for (int v = 0; v < 8; v++) begin
      LEDCtrl = vt[v].ledc; SwitchCtrl = vt[v].swc; io_wdata = vt[v].wdata;
      if (vt[v].do_tick) tick();
      else #1;
      check($sformatf("vec%0d_led", v), led_out, vt[v].exp_led);
      check($sformatf("vec%0d_rdata", v), io_rdata, vt[v].exp_rd);
    end
    LEDCtrl = 1'b0;

    // Scan of 0ABC9F.
    if (SEG_EN) begin
      found = 1'b0; waited = 0;
      while (!found && waited < 60) begin
        prev_an = seg_an;
        tick();
        waited++;
        if (prev_an != 8'hFE && seg_an == 8'hFE) found = 1'b1;
      end
      if (!found) begin
        checks++; errors++;
        $display("FAIL scan_sync: no FE anode within 60 cycles, got %h required FE", seg_an);
      end else begin
        for (int e = 0; e < 7; e++) begin
          for (int c = 0; c < S; c++) begin
            check($sformatf("scan%0d_an", e), {16'h0, seg_an}, {16'h0, st[e].an});
            check($sformatf("scan%0d_cat", e), {16'h0, seg_cat}, {16'h0, st[e].cat});
            tick();
          end
        end
      end
    end else begin
      for (int c = 0; c < 7 * S; c++) begin
        tick();
        check("off_an", {16'h0, seg_an}, 24'h0000FF);
        check("off_cat", {16'h0, seg_cat}, 24'h0000FF);
      end
    end

    // Randomised traffic against the model, with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst = (i >= 1500 && i < 1502) ? 1'b0 : 1'b1;
      r = int'($urandom_range(0, 15));
      if (r == 0) sw_in = W'($urandom);
      else if (r == 1) sw_in = sw_in ^ (W'(1) << $urandom_range(0, W - 1));
      LEDCtrl    = ($urandom_range(0, 3) == 0);
      io_wdata   = W'($urandom);
      SwitchCtrl = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_switch_led_ctrl.md
Name: io_switch_led_ctrl

Overview:
- Board-side IO peripheral directly downstream of the CPU top's IO bus.
- Consumes io_wdata / LEDCtrl to drive 24 LEDs and a 6-digit hex seven-segment display.
- Produces io_rdata from 24 synchronised, debounced slide switches, gated by SwitchCtrl.
- Single clock domain shared with the CPU.

Parameters:
- DEBOUNCE_CYCLES, 200000: consecutive cycles the synchronised switch vector must be unchanged before it is accepted.
- SCAN_CYCLES, 100000: cycles each seven-segment digit stays lit.
- IO_W, 24: switch, LED and data width.

Ports:
- clk  input  1  system clock, same as CPU.
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- io_wdata  input  IO_W  store data from CPU.
- LEDCtrl  input  1  LED write strobe, one cycle per store.
- SwitchCtrl  input  1  switch read select.
- io_rdata  output  IO_W  switch data to CPU.
- sw_in  input  IO_W  raw asynchronous switch pins.
- led_out  output  IO_W  LED pins, active high.
- seg_an  output  8  digit anodes, active low.
- seg_cat  output  8  cathodes {dp,g,f,e,d,c,b,a}, active low.

Behaviour:
- Reset (rst==0 at a rising edge):
  - sync stages, sw_prev and sw_stable all 0.
  - debounce counter 0; led_reg 0; scan counter 0; digit index 0.
  - After the edge: led_out=0, seg_an=8'hFF, seg_cat=8'hFF.
  - Reset mid-debounce discards the pending value. Reset mid-scan restarts at digit 0.
- Synchroniser:
  - Two flops per bit (s1<=sw_in; s2<=s1), then sw_prev<=s2.
  - Latency from pin to s2 is 2 cycles.
- Debounce:
  - Counter width is clog2(DEBOUNCE_CYCLES)+1.
  - If s2!=sw_prev, counter<=0.
  - Else if counter==DEBOUNCE_CYCLES-1, sw_stable<=s2 and counter holds (saturates).
  - Else counter<=counter+1.
  - Any change on any bit restarts the window for the whole vector.
  - Worst-case pin-to-sw_stable latency is DEBOUNCE_CYCLES+3 cycles.
- Read path:
  - Combinational, for single-cycle lw: io_rdata = SwitchCtrl ? sw_stable : 0.
  - No side effects on read.
- Write path:
  - At a rising edge with LEDCtrl==1, led_reg<=io_wdata. led_out=led_reg.
  - LEDCtrl and SwitchCtrl both high in the same cycle: the write is taken, and io_rdata returns sw_stable (pre-edge). Read and write are independent.
  - LEDCtrl held high for several cycles: the last value wins.
- Scan FSM:
  - States SCAN0..SCAN5, one per digit.
  - The scan counter counts 0..SCAN_CYCLES-1. At the terminal count it wraps to 0 and the digit index advances; SCAN5 wraps to SCAN0.
  - In state k: seg_an bit k is 0, all other bits 1; bits 7:6 are always 1.
  - Cathode nibble is led_reg[4k+3:4k], digit 0 being the least significant nibble. It is latched in the same cycle as the state change, so a write mid-digit shows from the next digit period.
  - Hex font, active low, dp off (bit7=1). 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - seg_an and seg_cat are registered outputs, updated at the state change.

Optional Feature:
- Macro IO_SEG7_EN.
- Defined: scan FSM and decoder are as above.
- Undefined: the FSM, counter and decoder are not built; seg_an=8'hFF and seg_cat=8'hFF at all times. Switch and LED paths are unchanged.

Test Plan:
- Bench settings: DEBOUNCE_CYCLES=4, SCAN_CYCLES=3, IO_W=24, IO_SEG7_EN defined.
- Reset: hold rst=0 for 2 cycles with sw_in=24'hFFFFFF and LEDCtrl=1 -> led_out=0, io_rdata=0 (SwitchCtrl=1), seg_an=FF. After release, io_rdata=24'hFFFFFF no earlier than 7 cycles and no later than 8 cycles.
- Debounce bounce: sw_in 0 -> 24'h000001, toggled every 2 cycles for 10 cycles, then steady 24'h000001 -> io_rdata stays 0 throughout the bouncing and becomes 24'h000001 exactly 7 cycles after the last edge.
- Read gating: sw_stable=24'hA5A5A5 with SwitchCtrl=0 -> io_rdata=0. With SwitchCtrl=1 -> io_rdata=24'hA5A5A5 in the same cycle.
- LED write: a 1-cycle pulse of LEDCtrl with io_wdata=24'h123456 -> led_out=24'h123456 the next cycle. Data changes with LEDCtrl=0 -> no change. Simultaneous LEDCtrl=1 and SwitchCtrl=1 -> both honoured.
- Scan: led_reg=24'h0ABC9F -> digits 0..5 show 8E,90,C6,83,88,C0 with anodes FE,FD,FB,F7,EF,DF. Each digit lasts 3 cycles; after DF the scan returns to FE.
- Macro off (recompile without IO_SEG7_EN): same write as the scan test -> seg_an and seg_cat stay FF; LED and switch results identical to the scenarios above.
